store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of 2, >=2).
REQ-002 SHALL have parameter CW, default 3, count width (log2(DEPTH)+1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cpu_we  input  1  processor store request.
REQ-006 SHALL have port cpu_re  input  1  processor load request.
REQ-007 SHALL have port cpu_addr  input  32  byte address of load/store (word-aligned, bits [1:0] ignored).
REQ-008 SHALL have port cpu_wdata  input  32  store data.
REQ-009 SHALL have port cpu_rdata  output  32  load data returned to processor.
REQ-010 SHALL have port stall  output  1  processor must hold its current instruction.
REQ-011 SHALL have port mem_we  output  1  write strobe to data memory.
REQ-012 SHALL have port mem_waddr  output  32  write address to data memory.
REQ-013 SHALL have port mem_wdata  output  32  write data to data memory.
REQ-014 SHALL have port mem_raddr  output  32  read address to data memory.
REQ-015 SHALL have port mem_rdata  input  32  combinational read data from data memory.
REQ-016 SHALL have port mem_ready  input  1  memory accepts the presented write this cycle.
REQ-017 SHALL have port count  output  CW  number of valid entries.

Function
REQ-018 SHALL be a circular FIFO of {word address, data}, head/tail pointers wrapping modulo DEPTH.
REQ-019 SHALL define full = (count == DEPTH), empty = (count == 0).
REQ-020 SHALL enqueue {cpu_addr, cpu_wdata} at the clock edge when cpu_we=1 and not full.
REQ-021 SHALL assert stall combinationally when cpu_we=1 and full; no enqueue that cycle (a same-cycle pop does not unblock it).
REQ-022 SHALL drive mem_we = !empty, with mem_waddr/mem_wdata from the head entry; mem_* are don't-care data when empty.
REQ-023 SHALL pop the head at the clock edge when mem_we=1 and mem_ready=1; one pop per cycle maximum.
REQ-024 SHALL keep count unchanged on simultaneous push and pop, +1 on push only, -1 on pop only.
REQ-025 SHALL drive mem_raddr = cpu_addr combinationally at all times.
REQ-026 SHALL compare loads against valid entries on word address (bits [31:2]) only.
REQ-027 SHALL return cpu_rdata = mem_rdata when cpu_re=1 and no valid entry matches.
REQ-028 SHALL ignore cpu_re when cpu_we=1 in the same cycle (store has priority; no match check).
REQ-029 SHALL never reorder stores; memory sees writes in program order.

Reset
REQ-030 SHALL on reset (asynchronous, no clock required) clear head, tail and count to 0.
REQ-031 SHALL after reset present mem_we=0, stall=0, count=0; entry storage need not be cleared.
REQ-032 SHALL discard all pending stores when reset asserts mid-operation; none are written afterwards.

Configuration
REQ-033 SHALL use macro STORE_BUFFER_FWD_EN to select load-hit handling.
REQ-034 SHALL with STORE_BUFFER_FWD_EN defined return, on a load hit, the data of the youngest matching entry (nearest tail), stall=0.
REQ-035 SHALL without STORE_BUFFER_FWD_EN assert stall on a load hit until no matching entry remains; cpu_rdata = mem_rdata.

Verification
REQ-036 SHALL test: reset, 3 stores (0x10<-0xA, 0x14<-0xB, 0x18<-0xC), mem_ready=0 -> count=3, mem_we=1, mem_waddr=0x10; mem_ready=1 -> writes 0x10,0x14,0x18 on three consecutive edges, count=0.
REQ-037 SHALL test: mem_ready=0, 5 back-to-back stores, DEPTH=4 -> stall=1 on 5th, count=4; mem_ready=1 one cycle -> pop; 5th enqueues next edge, count=4.
REQ-038 SHALL test: stores 0x20<-1 then 0x20<-2 buffered, load 0x20 -> FWD_EN: cpu_rdata=2, stall=0; without: stall=1 until both drained, then cpu_rdata=mem_rdata=2.
REQ-039 SHALL test: load 0x30, buffer holds only 0x20, mem_rdata=0x55 -> cpu_rdata=0x55, stall=0.
REQ-040 SHALL test: push and pop same edge at count=2 -> count stays 2; head/tail wrap past DEPTH-1 with FIFO order preserved over 10 stores.
REQ-041 SHALL test: reset asserted mid-clock with count=3 -> count=0, mem_we=0 immediately; no further memory writes.

Source files
------------

// File: rtl/store_buffer.sv
// Write-through store buffer: stores queue in a small FIFO and drain to data memory in order.
// Load-hit behaviour is chosen by STORE_BUFFER_FWD_EN (forward youngest match) vs. default (stall until drained).
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_we,
   input  logic          cpu_re,
   input  logic [31:0]   cpu_addr,
   input  logic [31:0]   cpu_wdata,
   output logic [31:0]   cpu_rdata,
   output logic          stall,
   output logic          mem_we,
   output logic [31:0]   mem_waddr,
   output logic [31:0]   mem_wdata,
   output logic [31:0]   mem_raddr,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_ready,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [PW-1:0] head_reg;
   logic [PW-1:0] tail_reg;
   logic [CW-1:0] count_reg;

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          load;
   logic          hit;
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] match;

   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);
   assign push  = cpu_we && !full;
   assign pop   = !empty && mem_ready;

   // A store in the same cycle takes priority, so the load is not looked up at all.
   assign load  = cpu_re && !cpu_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push)
            tail_reg <= tail_reg + PW'(1);
         if (pop)
            head_reg <= head_reg + PW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Entry storage is deliberately left out of reset; validity comes from head/count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_reg] <= cpu_addr;
         data_q[tail_reg] <= cpu_wdata;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_match
         logic [PW-1:0] offset;
         assign offset    = PW'(gi) - head_reg;
         assign valid[gi] = (CW'(offset) < count_reg);
         assign match[gi] = valid[gi] && (addr_q[gi][31:2] == cpu_addr[31:2]);
      end
   endgenerate

   assign hit       = load && (|match);
   assign mem_we    = !empty;
   assign mem_waddr = addr_q[head_reg];
   assign mem_wdata = data_q[head_reg];
   assign mem_raddr = cpu_addr;
   assign count     = count_reg;

`ifdef STORE_BUFFER_FWD_EN
   logic [31:0]   fwd_data;
   logic [PW-1:0] idx;

   // Walk oldest to youngest so the last match seen is the entry nearest the tail.
   always_comb begin
      fwd_data = '0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_reg + PW'(k);
         if (match[idx])
            fwd_data = data_q[idx];
      end
   end

   assign cpu_rdata = hit ? fwd_data : mem_rdata;
   assign stall     = cpu_we && full;
`else
   assign cpu_rdata = mem_rdata;
   assign stall     = (cpu_we && full) || hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer; expectations follow the build's STORE_BUFFER_FWD_EN setting.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_we;
   logic          cpu_re;
   logic [31:0]   cpu_addr;
   logic [31:0]   cpu_wdata;
   logic [31:0]   cpu_rdata;
   logic          stall;
   logic          mem_we;
   logic [31:0]   mem_waddr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_raddr;
   logic [31:0]   mem_rdata;
   logic          mem_ready;
   logic [CW-1:0] count;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [64];
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];

   store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .stall(stall), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .count(count)
   );

   always #5 clk = ~clk;

   // Data memory model: accepted writes are logged in order and applied to the array.
   always @(posedge clk) begin
      if (mem_we === 1'b1 && mem_ready === 1'b1) begin
         log_addr.push_back(mem_waddr);
         log_data.push_back(mem_wdata);
         model[mem_waddr[7:2]] = mem_wdata;
      end
   end

   assign mem_rdata = (mem_raddr[31:2] == 30'hC) ? 32'h55 : model[mem_raddr[7:2]];

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_store(input logic [31:0] a, input logic [31:0] d);
      cpu_we    = 1'b1;
      cpu_addr  = a;
      cpu_wdata = d;
      step();
      cpu_we    = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0; mem_ready = 1'b0;
      #2;
      total++; if (count !== 3'd0) begin $display("FAIL reset_count got=%0d want=0", count); bad++; end
      total++; if (mem_we !== 1'b0) begin $display("FAIL reset_mem_we got=%b want=0", mem_we); bad++; end
      total++; if (stall !== 1'b0) begin $display("FAIL reset_stall got=%b want=0", stall); bad++; end
      @(negedge clk);
      reset = 1'b0;
      step();
      total++; if (count !== 3'd0) begin $display("FAIL post_reset_count got=%0d want=0", count); bad++; end
      $display("test_reset done");
   endtask

   task automatic test_drain;
      int base;
      mem_ready = 1'b0;
      push_store(32'h10, 32'hA);
      push_store(32'h14, 32'hB);
      push_store(32'h18, 32'hC);
      #1;
      total++; if (count !== 3'd3) begin $display("FAIL drain_count got=%0d want=3", count); bad++; end
      total++; if (mem_we !== 1'b1) begin $display("FAIL drain_mem_we got=%b want=1", mem_we); bad++; end
      total++; if (mem_waddr !== 32'h10) begin $display("FAIL drain_head_addr got=%h want=10", mem_waddr); bad++; end
      base = log_addr.size();
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (mem_waddr !== 32'h10 + 32'(4 * i) || mem_wdata !== 32'hA + 32'(i)) begin
            $display("FAIL drain_write%0d got=%h/%h want=%h/%h", i, mem_waddr, mem_wdata, 32'h10 + 32'(4 * i), 32'hA + 32'(i));
            bad++;
         end
         step();
      end
      mem_ready = 1'b0;
      #1;
      total++; if (count !== 3'd0) begin $display("FAIL drain_empty_count got=%0d want=0", count); bad++; end
      total++; if (mem_we !== 1'b0) begin $display("FAIL drain_empty_mem_we got=%b want=0", mem_we); bad++; end
      total++; if (log_addr.size() !== base + 3) begin $display("FAIL drain_nwrites got=%0d want=%0d", log_addr.size() - base, 3); bad++; end
      $display("test_drain done");
   endtask

   task automatic test_full;
      int base;
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_store(32'h40 + 32'(4 * i), 32'h200 + 32'(i));
      cpu_we = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'h204;
      #1;
      total++; if (stall !== 1'b1) begin $display("FAIL full_stall got=%b want=1", stall); bad++; end
      total++; if (count !== 3'd4) begin $display("FAIL full_count got=%0d want=4", count); bad++; end
      step();
      total++; if (count !== 3'd4) begin $display("FAIL full_no_enqueue got=%0d want=4", count); bad++; end
      base = log_addr.size();
      mem_ready = 1'b1;
      #1;
      total++; if (stall !== 1'b1) begin $display("FAIL full_stall_with_pop got=%b want=1", stall); bad++; end
      step();
      total++; if (count !== 3'd3) begin $display("FAIL full_after_pop got=%0d want=3", count); bad++; end
      mem_ready = 1'b0;
      #1;
      total++; if (stall !== 1'b0) begin $display("FAIL full_unstall got=%b want=0", stall); bad++; end
      step();
      cpu_we = 1'b0;
      total++; if (count !== 3'd4) begin $display("FAIL full_fifth_enqueued got=%0d want=4", count); bad++; end
      mem_ready = 1'b1;
      repeat (4) step();
      mem_ready = 1'b0;
      total++; if (log_addr.size() !== base + 5) begin $display("FAIL full_nwrites got=%0d want=5", log_addr.size() - base); bad++; end
      for (int i = 0; i < 5; i++) begin
         if (log_addr.size() > base + i) begin
            total++;
            if (log_addr[base + i] !== 32'h40 + 32'(4 * i) || log_data[base + i] !== 32'h200 + 32'(i)) begin
               $display("FAIL full_order%0d got=%h/%h want=%h/%h", i, log_addr[base + i], log_data[base + i], 32'h40 + 32'(4 * i), 32'h200 + 32'(i));
               bad++;
            end
         end
      end
      $display("test_full done");
   endtask

   task automatic test_load_hit;
      mem_ready = 1'b0;
      push_store(32'h20, 32'h1);
      push_store(32'h20, 32'h2);
      cpu_re = 1'b1; cpu_addr = 32'h20;
      #1;
      total++; if (mem_raddr !== 32'h20) begin $display("FAIL hit_raddr got=%h want=20", mem_raddr); bad++; end
`ifdef STORE_BUFFER_FWD_EN
      total++; if (cpu_rdata !== 32'h2) begin $display("FAIL hit_fwd_data got=%h want=2", cpu_rdata); bad++; end
      total++; if (stall !== 1'b0) begin $display("FAIL hit_fwd_stall got=%b want=0", stall); bad++; end
      cpu_re = 1'b0;
      mem_ready = 1'b1;
      step(); step();
`else
      total++; if (stall !== 1'b1) begin $display("FAIL hit_stall got=%b want=1", stall); bad++; end
      mem_ready = 1'b1;
      step();
      #1;
      total++; if (stall !== 1'b1) begin $display("FAIL hit_stall_one_left got=%b want=1", stall); bad++; end
      step();
      #1;
      total++; if (stall !== 1'b0) begin $display("FAIL hit_stall_drained got=%b want=0", stall); bad++; end
      total++; if (cpu_rdata !== 32'h2) begin $display("FAIL hit_mem_data got=%h want=2", cpu_rdata); bad++; end
      cpu_re = 1'b0;
`endif
      mem_ready = 1'b0;
      total++; if (count !== 3'd0) begin $display("FAIL hit_count got=%0d want=0", count); bad++; end
      $display("test_load_hit done");
   endtask

   task automatic test_load_miss;
      mem_ready = 1'b0;
      push_store(32'h20, 32'h7);
      cpu_re = 1'b1; cpu_addr = 32'h30;
      #1;
      total++; if (cpu_rdata !== 32'h55) begin $display("FAIL miss_data got=%h want=55", cpu_rdata); bad++; end
      total++; if (stall !== 1'b0) begin $display("FAIL miss_stall got=%b want=0", stall); bad++; end
      cpu_addr = 32'h23;
      #1;
`ifdef STORE_BUFFER_FWD_EN
      total++; if (cpu_rdata !== 32'h7) begin $display("FAIL byte_addr_fwd got=%h want=7", cpu_rdata); bad++; end
`else
      total++; if (stall !== 1'b1) begin $display("FAIL byte_addr_stall got=%b want=1", stall); bad++; end
`endif
      cpu_we = 1'b1; cpu_wdata = 32'h9;
      #1;
      total++; if (stall !== 1'b0) begin $display("FAIL store_priority_stall got=%b want=0", stall); bad++; end
      step();
      cpu_we = 1'b0; cpu_re = 1'b0;
      total++; if (count !== 3'd2) begin $display("FAIL store_priority_count got=%0d want=2", count); bad++; end
      mem_ready = 1'b1;
      step(); step();
      mem_ready = 1'b0;
      $display("test_load_miss done");
   endtask

   task automatic test_wrap;
      int base;
      base = log_addr.size();
      mem_ready = 1'b0;
      push_store(32'h80, 32'h1000);
      push_store(32'h84, 32'h1001);
      total++; if (count !== 3'd2) begin $display("FAIL wrap_prefill got=%0d want=2", count); bad++; end
      mem_ready = 1'b1;
      for (int i = 2; i < 10; i++) begin
         cpu_we = 1'b1; cpu_addr = 32'h80 + 32'(4 * i); cpu_wdata = 32'h1000 + 32'(i);
         step();
         total++; if (count !== 3'd2) begin $display("FAIL wrap_count%0d got=%0d want=2", i, count); bad++; end
      end
      cpu_we = 1'b0;
      step(); step();
      mem_ready = 1'b0;
      total++; if (log_addr.size() !== base + 10) begin $display("FAIL wrap_nwrites got=%0d want=10", log_addr.size() - base); bad++; end
      for (int i = 0; i < 10; i++) begin
         if (log_addr.size() > base + i) begin
            total++;
            if (log_addr[base + i] !== 32'h80 + 32'(4 * i) || log_data[base + i] !== 32'h1000 + 32'(i)) begin
               $display("FAIL wrap_order%0d got=%h/%h want=%h/%h", i, log_addr[base + i], log_data[base + i], 32'h80 + 32'(4 * i), 32'h1000 + 32'(i));
               bad++;
            end
         end
      end
      $display("test_wrap done");
   endtask

   task automatic test_reset_mid;
      int base;
      mem_ready = 1'b0;
      push_store(32'hC0, 32'h31);
      push_store(32'hC4, 32'h32);
      push_store(32'hC8, 32'h33);
      #1;
      total++; if (count !== 3'd3) begin $display("FAIL rst_mid_pre got=%0d want=3", count); bad++; end
      #2;
      reset = 1'b1;
      #1;
      total++; if (count !== 3'd0) begin $display("FAIL rst_mid_count got=%0d want=0", count); bad++; end
      total++; if (mem_we !== 1'b0) begin $display("FAIL rst_mid_mem_we got=%b want=0", mem_we); bad++; end
      base = log_addr.size();
      @(negedge clk);
      reset = 1'b0;
      mem_ready = 1'b1;
      repeat (5) step();
      mem_ready = 1'b0;
      total++; if (log_addr.size() !== base) begin $display("FAIL rst_mid_writes got=%0d want=0", log_addr.size() - base); bad++; end
      total++; if (count !== 3'd0) begin $display("FAIL rst_mid_final got=%0d want=0", count); bad++; end
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_drain();
      test_full();
      test_load_hit();
      test_load_miss();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
